mux_pipe: RTL

Parametrised N-input, WIDTH-bit select mux with a registered valid/ready output stage. It succeeds the combinational 2:1 Mux1 in the datapath. It is used where pipelined stages need a stall-tolerant operand/writeback select, e.g. forwarding or writeback source select.
Select is binary-encoded or one-hot, chosen by parameter. A 2-entry skid buffer gives full throughput, and in_ready depends only on registered state.

---
 rtl/mux_pipe_pkg.sv | 56 +++++
 rtl/mux_sel_comb.sv | 37 +++
 rtl/mux_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg
//   Shared types and helpers for the mux_pipe block and its selector.
//   - mux_pipe_state_e : occupancy of the output stage (main register M, skid S)
//   - sel_dec_t        : decoded select (input index plus illegal flag)
//   - sel_width()      : select port width for a given NUM_IN / ONEHOT setting
//   - sel_decode()     : binary or one-hot select decode, up to 16 inputs
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mux_pipe_state_e;

  typedef struct packed {
    logic [3:0] idx;
    logic       illegal;
  } sel_dec_t;

  // Binary mode never needs fewer than one select bit, even for two inputs.
  function automatic int sel_width(input int num_in, input int onehot);
    int w;
    if (onehot != 0) begin
      w = num_in;
    end else if (num_in <= 2) begin
      w = 1;
    end else begin
      w = $clog2(num_in);
    end
    return w;
  endfunction

  // sel arrives zero-extended to 16 bits. One-hot: exactly one set bit is
  // legal. Binary: any value at or above num_in is illegal.
  function automatic sel_dec_t sel_decode(input logic [15:0] sel,
                                          input int num_in,
                                          input int onehot);
    sel_dec_t r;
    int hits;
    r.idx     = 4'd0;
    r.illegal = 1'b0;
    hits      = 0;
    if (onehot != 0) begin
      for (int i = 0; i < 16; i++) begin
        hits  = hits + int'(sel[i]);
        r.idx = sel[i] ? 4'(i) : r.idx;
      end
      r.illegal = (hits != 1);
    end else begin
      r.idx     = sel[3:0];
      r.illegal = (sel >= 16'(num_in));
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb
//   Purely combinational NUM_IN:1 selector with an illegal-select flag.
//   An illegal select yields all-zero data. With NUM_IN=2, ONEHOT=0 it is a
//   drop-in replacement for the old 2:1 Mux1.
//   Ports:
//     in_data  [NUM_IN*WIDTH] packed inputs, input i at [i*WIDTH +: WIDTH]
//     sel      [SEL_W]        binary index or one-hot vector
//     data     [WIDTH]        selected input, or 0 when illegal
//     illegal  [1]            select does not name exactly one input
module mux_sel_comb
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int ONEHOT = 0,
  localparam int SEL_W = sel_width(NUM_IN, ONEHOT)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    illegal
);

  sel_dec_t dec_s;

  // Decode select and OR together the single matching input (AND-OR mux).
  always_comb begin
    dec_s   = sel_decode(16'(sel), NUM_IN, ONEHOT);
    illegal = dec_s.illegal;
    data    = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      data = data | ({WIDTH{(!dec_s.illegal) && (dec_s.idx == 4'(i))}}
                     & in_data[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe
//   N-input select mux with a registered valid/ready output stage and a
//   2-entry skid buffer (main register M, skid register S) for full
//   throughput. in_ready is a registered decode of the occupancy state, so
//   there is no combinational path from out_ready to in_ready.
//   Optional feature macro: MUX_PIPE_STATS_EN adds beat_cnt / err_cnt.
//   Ports:
//     clk, reset           rising-edge clock, async active-high reset
//     in_data, sel         packed inputs and select, sampled with in_valid
//     in_valid, in_ready   upstream handshake
//     out_data, out_valid  registered selected data
//     out_ready            downstream handshake
//     sel_err              one-cycle pulse after accepting an illegal select
//     beat_cnt (opt)       output transfers, wrapping 32-bit
//     err_cnt  (opt)       sel_err pulses, saturating at 16'hFFFF
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int ONEHOT = 0,
  localparam int SEL_W = sel_width(NUM_IN, ONEHOT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef MUX_PIPE_STATS_EN
  ,
  output logic [31:0]             beat_cnt,
  output logic [15:0]             err_cnt
`endif
);

  mux_pipe_state_e  state_r;
  logic [WIDTH-1:0] m_data_r;
  logic [WIDTH-1:0] s_data_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             sel_err_r;
  logic [WIDTH-1:0] sel_data_s;
  logic             illegal_s;
  logic             accept_s;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .ONEHOT (ONEHOT)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .data    (sel_data_s),
    .illegal (illegal_s)
  );

  assign accept_s  = in_valid && in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = m_data_r;
  assign sel_err   = sel_err_r;

  // Output-stage state machine: M/S occupancy with registered handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      m_data_r    <= {WIDTH{1'b0}};
      s_data_r    <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      sel_err_r   <= 1'b0;
    end else begin
      // Illegal beats still flow as data 0; flag them one cycle later.
      sel_err_r <= accept_s && illegal_s;
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            m_data_r    <= sel_data_s;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (accept_s && out_ready) begin
            m_data_r <= sel_data_s;
          end else if (accept_s) begin
            // M is stalled: park the new beat in S and stop accepting.
            s_data_r   <= sel_data_s;
            in_ready_r <= 1'b0;
            state_r    <= TWO;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= EMPTY;
          end else begin
            state_r <= ONE;
          end
        end
        TWO: begin
          if (out_ready) begin
            m_data_r   <= s_data_r;
            in_ready_r <= 1'b1;
            state_r    <= ONE;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= EMPTY;
        end
      endcase
    end
  end

`ifdef MUX_PIPE_STATS_EN
  logic [31:0] beat_cnt_r;
  logic [15:0] err_cnt_r;

  // Transfer counter wraps; error counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_r <= 32'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      if (out_valid_r && out_ready) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end
      if (sel_err_r && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign beat_cnt = beat_cnt_r;
  assign err_cnt  = err_cnt_r;
`endif

endmodule
